// File: rtl/ysyx_24070016_mem_pkg.sv
// Shared types and constants for the memory responder.
package ysyx_24070016_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE  = 32'h8000_0000;
    localparam int          DEF_DEPTH = 4096;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  LAT_MASK  = 4'hF;

endpackage

// File: rtl/ysyx_24070016_mem_responder_if.sv
// Request/response bus between the core memory port and the responder.
interface ysyx_24070016_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_24070016_mem_lfsr.sv
// 16-bit Fibonacci LFSR used for random response latency
// (only built when YSYX_24070016_MEM_RAND_LAT_EN is defined).
module ysyx_24070016_mem_lfsr
    import ysyx_24070016_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (en) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/ysyx_24070016_mem_responder.sv
// Word-addressed memory responder with valid/ready request and response channels.
// Define YSYX_24070016_MEM_RAND_LAT_EN for LFSR-driven per-transaction latency.
module ysyx_24070016_mem_responder
    import ysyx_24070016_mem_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(DEF_BASE),
    parameter int                LAT    = 2
)(
    input  logic                           clk,
    input  logic                           rst,
    ysyx_24070016_mem_responder_if.slave   bus
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(DEPTH) << 2;

    state_t            state;
    logic [3:0]        cnt;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;

    logic [31:0]       mem [DEPTH];

    logic              hs;
    logic [3:0]        lat_load;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_wen;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wmask;
    logic [ADDR_W-1:0] acc_off;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_err;
    logic              enter_resp;
    logic              mem_we;

    assign hs = bus.req_valid && req_ready_q;

`ifdef YSYX_24070016_MEM_RAND_LAT_EN
    logic [15:0] lfsr_value;

    ysyx_24070016_mem_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (hs),
        .value (lfsr_value)
    );

    assign lat_load = lfsr_value[3:0] & LAT_MASK;
`else
    assign lat_load = 4'(LAT);
`endif

    // A zero-latency request reaches RESP on its acceptance edge, before the
    // capture registers hold it, so the access uses the live bus in IDLE.
    always_comb begin
        acc_addr  = addr_q;
        acc_wen   = wen_q;
        acc_wdata = wdata_q;
        acc_wmask = wmask_q;
        if (state == IDLE) begin
            acc_addr  = bus.req_addr;
            acc_wen   = bus.req_wen;
            acc_wdata = bus.req_wdata;
            acc_wmask = bus.req_wmask;
        end
    end

    // Subtraction wraps for addresses below BASE, so one unsigned compare covers both bounds.
    assign acc_off    = acc_addr - BASE;
    assign acc_idx    = acc_off[IDX_W+1:2];
    assign acc_err    = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_off} >= SPAN);
    assign enter_resp = (state == IDLE && hs && lat_load == 4'd0) ||
                        (state == WAIT && cnt == 4'd0);
    assign mem_we     = !rst && enter_resp && acc_wen && !acc_err;

    // NOTE: the storage array has no reset; only control state is cleared, which
    // lets the array map onto RAM and keeps contents across a transaction reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= 32'h0;
            wmask_q      <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        addr_q      <= bus.req_addr;
                        wen_q       <= bus.req_wen;
                        wdata_q     <= bus.req_wdata;
                        wmask_q     <= bus.req_wmask;
                        req_ready_q <= 1'b0;
                        if (lat_load == 4'd0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= lat_load - 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= acc_err;
                resp_rdata_q <= (acc_wen || acc_err) ? 32'h0 : mem[acc_idx];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_24070016_mem_responder.sv
// Directed scoreboard bench for ysyx_24070016_mem_responder.
module tb_ysyx_24070016_mem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          TMO   = 40;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    exp_t        sb [$];
    logic [31:0] model [int unsigned];

    ysyx_24070016_mem_responder_if #(.ADDR_W(32)) bus ();

    ysyx_24070016_mem_responder #(
        .ADDR_W (32),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .LAT    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(DEPTH * 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_req(input logic v);
        bus.req_valid = v;
        bus.req_addr  = $urandom;
        bus.req_wen   = 1'($urandom);
        bus.req_wdata = $urandom;
        bus.req_wmask = 4'($urandom);
    endtask

    // Build the expected response from the spec model and queue it.
    task automatic expect_resp(input logic [31:0] a, input bit w,
                               input logic [31:0] d, input logic [3:0] m);
        exp_t        e;
        int unsigned idx;
        logic [31:0] word;
        e.err   = addr_err(a);
        e.rdata = 32'h0;
        if (!e.err) begin
            idx = (a - BASE) >> 2;
            if (w) begin
                word = model.exists(idx) ? model[idx] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) word[8*b +: 8] = d[8*b +: 8];
                end
                if (m != 4'h0) model[idx] = word;
            end else begin
                e.rdata = model[idx];
            end
        end
        sb.push_back(e);
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input bit w,
                       input logic [31:0] d, input logic [3:0] m,
                       input int hold, input bit early_ready);
        exp_t e;
        int   n;
        expect_resp(a, w, d, m);
        bus.resp_ready = early_ready;
        check({tag, "_req_ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_wmask = m;
        tick();
        garbage_req(1'b0);
        n = 0;
        while (!bus.resp_valid && n < TMO) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        if (!bus.resp_valid) begin
            check({tag, "_timeout"}, 32'(bus.resp_valid), 32'd1);
            return;
        end
`ifndef YSYX_24070016_MEM_RAND_LAT_EN
        check({tag, "_latency"}, 32'(n), 32'(LAT));
`endif
        check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
        check({tag, "_req_ready_resp"}, 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            garbage_req(1'b1);
            tick();
            check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, e.rdata);
            check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(e.err));
            check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        garbage_req(1'b0);
        bus.resp_ready = 1'b1;
        if (!early_ready) tick();
        else tick();
        check({tag, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_done_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.resp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
        check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    endtask

    initial begin
        bus.resp_ready = 1'b0;
        garbage_req(1'b0);

        rst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        txn("wr_full",  32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        txn("rd_full",  32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        check("rd_full_const", model[4], 32'hDEAD_BEEF);

        txn("wr_mask",  32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, 0, 1'b0);
        txn("rd_mask",  32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        check("rd_mask_const", model[4], 32'hDE22_BE44);

        txn("wr_base",  32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        txn("err_low",  32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        txn("err_high", 32'h8000_4000, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        txn("err_mis",  32'h8000_0002, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        txn("rd_base",  32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        txn("wr_zmask", 32'h8000_0010, 1'b1, 32'h0000_0000, 4'h0, 0, 1'b0);
        txn("rd_zmask", 32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 1'b0);

        txn("wr_last",  32'h8000_3FFC, 1'b1, 32'h5A5A_A5A5, 4'hF, 0, 1'b1);
        txn("rd_last",  32'h8000_3FFC, 1'b0, 32'h0,         4'h0, 0, 1'b1);

        txn("rd_bp",    32'h8000_0010, 1'b0, 32'h0,         4'h0, 5, 1'b0);

        // Reset while a write sits in WAIT: the write must never land.
        txn("wr_old",   32'h8000_0020, 1'b1, 32'h0123_4567, 4'hF, 0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0020;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 32'h89AB_CDEF;
        bus.req_wmask = 4'hF;
        tick();
        garbage_req(1'b0);
        check("mid_in_wait", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        tick();
        txn("rd_old",   32'h8000_0020, 1'b0, 32'h0,         4'h0, 0, 1'b0);
        check("rd_old_const", model[8], 32'h0123_4567);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_24070016_mem_responder.md
Name: ysyx_24070016_mem_responder

Overview:
- Memory-side responder for the core's 32-bit instruction/data memory port.
- Accepts one read or write request at a time over a valid/ready handshake and holds a word-addressed storage array.
- Returns read data or a write acknowledgement after a programmable latency.
- Used in simulation and FPGA builds in place of the current zero-latency combinational memory, so the core's fetch/LSU handshake logic can be exercised.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH, 4096, storage depth in 32-bit words; must be a power of two.
- BASE, 32'h80000000, byte address mapped to word 0.
- LAT, 2, fixed cycles between request acceptance and the response (0..15).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_wmask  in  4  byte enables for writes; bit i enables byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  read data (0 for writes and errors).
- resp_err  out  1  access error.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter 0. Memory contents are not reset.
- FSM states:
  - IDLE: req_ready=1. Handshake (req_valid & req_ready) captures addr, wen, wdata and wmask into registers. Go to WAIT if LAT>0, else RESP.
  - WAIT: req_ready=0. Counter loads LAT-1 on entry and decrements each cycle. At count 0 go to RESP.
  - RESP: resp_valid=1, outputs held stable. On resp_valid & resp_ready return to IDLE.
- Latency: request accepted at edge T gives resp_valid high in cycle T+1+LAT.
- Back-to-back: no overlap; next acceptance is possible in the cycle after the response handshake.
- Memory access executes on the transition into RESP:
  - Index = (addr-BASE)>>2 over DEPTH words.
  - Reads latch the word into resp_rdata.
  - Writes update only the bytes enabled by wmask; resp_rdata=0.
- Errors (resp_err=1):
  - addr[1:0]!=0, or addr outside [BASE, BASE+4*DEPTH).
  - No storage update; resp_rdata=0.
- Write with wmask=0: no update, no error.
- resp_ready held high before RESP: ignored; it has effect only while resp_valid=1.
- Request inputs change while not ready: ignored; only the registered copy is used.
- Reset mid-transaction: transaction dropped. Writes not yet committed (still in WAIT) are lost. Return to IDLE next cycle.
- Address arithmetic uses ADDR_W-bit unsigned compare; wrap-around below BASE is flagged as an error.

Optional Feature:
- Macro YSYX_24070016_MEM_RAND_LAT_EN.
- When defined, the WAIT count loads a per-transaction value from a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on rst). The count is lfsr[3:0] & LAT_MASK, where LAT_MASK = 4'hF. The LFSR advances once per accepted request.
- When undefined, latency is fixed at LAT and no LFSR logic exists.

Decomposition:
- Package ysyx_24070016_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - BASE and DEPTH defaults;
  - LFSR seed and tap constants.
- One sub-module, ysyx_24070016_mem_lfsr (16-bit Fibonacci LFSR, enable input). It is instantiated only under the macro.

Test Plan:
1. Reset with rst=1 for 2 cycles: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
2. Write then read:
   - Write addr 0x80000010, data 0xDEADBEEF, mask 0xF, LAT=2: resp_valid 3 cycles after acceptance, err=0, rdata=0.
   - Read of the same address returns 0xDEADBEEF.
3. Byte mask: write 0x11223344 with mask 4'b0101 over 0xDEADBEEF, then read: 0xDE22BE44.
4. Errors, no storage change (verified by a following read):
   - read 0x7FFFFFFC gives err=1, rdata=0;
   - read 0x80004000 (DEPTH=4096) gives err=1;
   - write 0x80000002 gives err=1.
5. Backpressure: hold resp_ready=0 for 5 cycles in RESP.
   - resp_valid and rdata stay stable and req_ready=0.
   - Raising resp_ready gives IDLE next cycle.
6. Reset mid-transaction: assert rst during WAIT of a write to 0x80000020. Outputs return to reset values, and a subsequent read shows the old contents.
